// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Holds the fetch FSM state encoding, the PC increment and the default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC select for fetch: a redirect wins, otherwise advance by one word or hold.
// Ports: pc, redirect, redirect_pc, advance in; pc_next, pc_plus_four out.
module fetch_pc_next
    import fetch_pkg::*;
(
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic [31:0] pc_plus_four
);

    // Wraps modulo 2^32.
    assign pc_plus_four = pc + PC_STEP;

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (advance) begin
            pc_next = pc_plus_four;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: one outstanding imem request, one-entry IF/ID buffer,
// EX redirects with stale-response drop. Ports: clk, rst, redirect_*, imem_req_*,
// imem_rsp_*, if_* ; fetch_misalign only with macro FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus_four,
    output logic [31:0]       if_instr
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              fetch_misalign
`endif
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, pc_plus_four, tgt;
    logic              drop, drop_n;
    logic              hs, pend, rsp, load;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halt, halt_n, misalign;

    assign tgt      = redirect_pc;
    assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign tgt = redirect_pc & ~32'h3;
`endif

    // Only issue when the buffer is empty or being drained this cycle,
    // so a returning response can never overwrite a stalled entry.
    assign imem_req_valid = (state == S_REQ) && (!if_valid || if_ready);
    assign imem_req_addr  = pc;
    assign hs             = imem_req_valid && imem_req_ready;

    // A response is outstanding in S_WAIT, or in a halted S_IDLE that
    // still owes a stale response.
    assign pend = (state == S_WAIT) || ((state == S_IDLE) && drop);
    assign rsp  = pend && imem_rsp_valid;
    assign load = (state == S_WAIT) && imem_rsp_valid
               && !drop && !redirect_valid;

    fetch_pc_next u_pc_next (
        .redirect     (redirect_valid),
        .redirect_pc  (tgt),
        .advance      (load),
        .pc           (pc),
        .pc_next      (pc_n),
        .pc_plus_four (pc_plus_four)
    );

    always_comb begin
        state_n = state;
        drop_n  = drop;
`ifdef FETCH_MISALIGN_TRAP_EN
        halt_n  = halt;
`endif
        unique case (state)
            S_IDLE: begin
                if (rsp) drop_n = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                state_n = halt ? S_IDLE : S_REQ;
`else
                state_n = S_REQ;
`endif
            end
            S_REQ: begin
                if (hs) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_n = S_REQ;
                    drop_n  = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (redirect_valid) begin
            if (rsp) begin
                // Response in the redirect cycle is simply not used.
                state_n = S_REQ;
                drop_n  = 1'b0;
            end else if (pend || hs) begin
                state_n = S_WAIT;
                drop_n  = 1'b1;
            end else begin
                state_n = S_REQ;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            halt_n = misalign;
            if (misalign) state_n = S_IDLE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            pc              <= RESET_PC;
            drop            <= 1'b0;
            if_valid        <= 1'b0;
            if_pc           <= '0;
            if_pc_plus_four <= '0;
            if_instr        <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt            <= 1'b0;
            fetch_misalign  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            pc    <= pc_n;
            drop  <= drop_n;
            if (redirect_valid) begin
                if_valid <= 1'b0;
            end else if (load) begin
                if_valid        <= 1'b1;
                if_pc           <= pc;
                if_pc_plus_four <= pc_plus_four;
                if_instr        <= imem_rsp_data;
            end else if (if_ready) begin
                if_valid <= 1'b0;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            halt           <= halt_n;
            fetch_misalign <= misalign;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-cycle directed vector table plus
// hand sequences for misaligned redirect and steady-state throughput.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_four;
    logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_pc_plus_four (if_pc_plus_four),
        .if_instr        (if_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misalign  (fetch_misalign)
`endif
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rqr;
        logic        rsv;
        logic [31:0] rsd;
        logic        ifr;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic [31:0] e_ins;
    } vec_t;

    vec_t        vq[$];
    int          checks = 0;
    int          passed = 0;
    int          got    = 0;
    logic        pend_m = 1'b0;
    logic [31:0] paddr  = 32'h0;

    function automatic vec_t mk(
        input logic [31:0] r, input logic [31:0] rv, input logic [31:0] rpc,
        input logic [31:0] rqr, input logic [31:0] rsv, input logic [31:0] rsd,
        input logic [31:0] ifr, input logic [31:0] rqv, input logic [31:0] addr,
        input logic [31:0] ifv, input logic [31:0] pc, input logic [31:0] p4,
        input logic [31:0] ins);
        vec_t v;
        v.rst    = r[0];
        v.rv     = rv[0];
        v.rpc    = rpc;
        v.rqr    = rqr[0];
        v.rsv    = rsv[0];
        v.rsd    = rsd;
        v.ifr    = ifr[0];
        v.e_rqv  = rqv[0];
        v.e_addr = addr;
        v.e_ifv  = ifv[0];
        v.e_pc   = pc;
        v.e_p4   = p4;
        v.e_ins  = ins;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic apply(input vec_t v, input int i);
        @(negedge clk);
        rst            = v.rst;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        imem_req_ready = v.rqr;
        imem_rsp_valid = v.rsv;
        imem_rsp_data  = v.rsd;
        if_ready       = v.ifr;
        #1;
        chk($sformatf("v%0d req_valid", i), {31'b0, imem_req_valid},
            {31'b0, v.e_rqv});
        chk($sformatf("v%0d req_addr", i), imem_req_addr, v.e_addr);
        chk($sformatf("v%0d if_valid", i), {31'b0, if_valid},
            {31'b0, v.e_ifv});
        if (v.e_ifv) begin
            chk($sformatf("v%0d if_pc", i), if_pc, v.e_pc);
            chk($sformatf("v%0d if_pc4", i), if_pc_plus_four, v.e_p4);
            chk($sformatf("v%0d if_instr", i), if_instr, v.e_ins);
        end
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if_ready       = 1'b1;

        // rst rv rpc rqr rsv rsd ifr | rqv addr ifv pc p4 ins
        vq.push_back(mk(0,0,0,1,0,0,1, 0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,1,0,0,1, 1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,1,1,'h11,1, 0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,1,0,0,1, 1,4,1,0,4,'h11));
        vq.push_back(mk(0,0,0,1,1,'h0050_0093,1, 0,4,0,0,0,0));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0,0,0,1,0,0,0, 0,8,1,4,8,'h0050_0093));
        vq.push_back(mk(0,0,0,1,0,0,1, 1,8,1,4,8,'h0050_0093));
        vq.push_back(mk(0,1,'h100,1,0,0,1, 0,8,0,0,0,0));
        vq.push_back(mk(0,0,0,1,1,'h33,1, 0,'h100,0,0,0,0));
        vq.push_back(mk(0,0,0,1,0,0,1, 1,'h100,0,0,0,0));
        vq.push_back(mk(0,0,0,1,1,'h44,1, 0,'h100,0,0,0,0));
        vq.push_back(mk(0,0,0,1,0,0,1, 1,'h104,1,'h100,'h104,'h44));
        vq.push_back(mk(0,1,'h200,1,1,'h55,1, 0,'h104,0,0,0,0));
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(0,0,0,0,0,0,1, 1,'h200,0,0,0,0));
        vq.push_back(mk(0,0,0,1,0,0,1, 1,'h200,0,0,0,0));
        vq.push_back(mk(1,0,0,1,0,0,1, 0,'h200,0,0,0,0));
        vq.push_back(mk(0,0,0,1,1,'h66,1, 0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,1,0,0,1, 1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,1,1,'h77,1, 0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,1, 1,4,1,0,4,'h77));
        vq.push_back(mk(0,1,'hFFFF_FFFC,0,0,0,1, 1,4,0,0,0,0));
        vq.push_back(mk(0,0,0,1,0,0,1, 1,'hFFFF_FFFC,0,0,0,0));
        vq.push_back(mk(0,0,0,1,1,'h88,1, 0,'hFFFF_FFFC,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,1,
                        1,0,1,'hFFFF_FFFC,0,'h88));
        vq.push_back(mk(0,0,0,0,0,0,1, 1,0,0,0,0,0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst req_addr", imem_req_addr, 32'h0);
        chk("rst if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst if_pc", if_pc, 32'h0);
        chk("rst if_pc4", if_pc_plus_four, 32'h0);
        chk("rst if_instr", if_instr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst misalign", {31'b0, fetch_misalign}, 32'h0);
`endif

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // Misaligned redirect
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        if_ready       = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis pulse", {31'b0, fetch_misalign}, 32'h1);
        chk("mis no req", {31'b0, imem_req_valid}, 32'h0);
        @(negedge clk);
        #1;
        chk("mis pulse end", {31'b0, fetch_misalign}, 32'h0);
        chk("mis halted", {31'b0, imem_req_valid}, 32'h0);
`else
        chk("align req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("align req_addr", imem_req_addr, 32'h100);
`endif
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("vec req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("vec req_addr", imem_req_addr, 32'h300);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("vec misalign", {31'b0, fetch_misalign}, 32'h0);
`endif

        // Zero-wait memory: one instruction every two cycles
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            imem_req_ready = 1'b1;
            if_ready       = 1'b1;
            imem_rsp_valid = pend_m;
            imem_rsp_data  = 32'hA000_0000 ^ paddr;
            pend_m         = 1'b0;
            #1;
            if (imem_req_valid) begin
                pend_m = 1'b1;
                paddr  = imem_req_addr;
            end
            if (if_valid) begin
                chk($sformatf("tp%0d if_pc", got), if_pc,
                    32'h300 + 32'd4 * got);
                chk($sformatf("tp%0d if_instr", got), if_instr,
                    32'hA000_0000 ^ (32'h300 + 32'd4 * got));
                got++;
            end
        end
        chk("tp count", got, 32'd5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
